// File: rtl/draw_arbiter.sv
// draw_arbiter: round-robin sharing of one fill engine among NUM_REQ sprite controllers.
// Optional ARB_WATCHDOG_EN aborts a BUSY grant after WDOG_CYCLES cycles and pulses timeout.
module draw_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int C_W         = 3,
  parameter int WDOG_CYCLES = 2_000_000,
  localparam int GID_W      = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_erase,
  input  logic [NUM_REQ*X_W-1:0] req_x,
  input  logic [NUM_REQ*Y_W-1:0] req_y,
  input  logic [NUM_REQ*C_W-1:0] req_color,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   busy,
  output logic [GID_W-1:0]       grant_id,
  output logic [X_W-1:0]         eng_x,
  output logic [Y_W-1:0]         eng_y,
  output logic [C_W-1:0]         eng_color,
  output logic                   eng_draw,
  output logic                   eng_erase,
  input  logic                   eng_draw_done,
  input  logic                   eng_erase_done,
  output logic                   timeout
);
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  state_t state_q, state_d;
  logic [GID_W-1:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, win, off;
  logic [X_W-1:0] eng_x_q, eng_x_d, sel_x;
  logic [Y_W-1:0] eng_y_q, eng_y_d, sel_y;
  logic [C_W-1:0] eng_color_q, eng_color_d, sel_c;
  logic op_q, op_d, sel_op, done_m, wdog_hit;
  logic [NUM_REQ-1:0] rot;
  logic [GID_W:0] sum;
  // rotate requests so bit 0 is rr_ptr; the lowest set bit is the offset of the winner
  always_comb begin
    rot = NUM_REQ'({req, req} >> rr_ptr_q);
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) off = rot[i] ? GID_W'(i) : off;
    sum = {1'b0, rr_ptr_q} + {1'b0, off};
    win = (sum >= (GID_W+1)'(NUM_REQ)) ? GID_W'(sum - (GID_W+1)'(NUM_REQ)) : GID_W'(sum);
    sel_x  = '0;
    sel_y  = '0;
    sel_c  = '0;
    sel_op = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == GID_W'(i)) begin
        sel_x  = req_x[i*X_W +: X_W];
        sel_y  = req_y[i*Y_W +: Y_W];
        sel_c  = req_color[i*C_W +: C_W];
        sel_op = req_erase[i];
      end
    end
  end
  assign done_m = op_q ? eng_erase_done : eng_draw_done;
`ifdef ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic timeout_q, timeout_d;
  assign wdog_hit = (state_q == BUSY) && (wdog_q == WD_W'(WDOG_CYCLES - 1));
  always_comb begin
    wdog_d    = (state_q == BUSY) ? wdog_q + 1'b1 : '0;
    timeout_d = wdog_hit && !done_m;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign wdog_hit = 1'b0;
  assign timeout  = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    eng_x_d     = eng_x_q;
    eng_y_d     = eng_y_q;
    eng_color_d = eng_color_q;
    op_d        = op_q;
    if (state_q == IDLE && |req) begin
      state_d     = BUSY;
      grant_id_d  = win;
      eng_x_d     = sel_x;
      eng_y_d     = sel_y;
      eng_color_d = sel_c;
      op_d        = sel_op;
    end
    if (state_q == BUSY && (done_m || wdog_hit)) state_d = ACK;
    if (state_q == ACK) begin
      state_d  = IDLE;
      rr_ptr_d = (grant_id_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      eng_x_q     <= '0;
      eng_y_q     <= '0;
      eng_color_q <= '0;
      op_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      eng_x_q     <= eng_x_d;
      eng_y_q     <= eng_y_d;
      eng_color_q <= eng_color_d;
      op_q        <= op_d;
    end
  end
  always_comb begin
    ack = '0;
    for (int i = 0; i < NUM_REQ; i++) ack[i] = (state_q == ACK) && (grant_id_q == GID_W'(i));
  end
  assign busy      = state_q != IDLE;
  assign eng_draw  = (state_q == BUSY) && !op_q;
  assign eng_erase = (state_q == BUSY) && op_q;
  assign grant_id  = grant_id_q;
  assign eng_x     = eng_x_q;
  assign eng_y     = eng_y_q;
  assign eng_color = eng_color_q;
endmodule
